tcdm_pipe_resp: RTL and testbench

- Response-channel companion to the TCDM request pipe. It tracks requests accepted at the initiator side and collects read data from the SCM port (never pipelined) and the SRAM port (optionally pipelined on request and/or response).
- It returns a single r_valid/ID/rdata/opc response stream to the initiator.
- It sits between the low-latency interconnect slave port and the SCM/SRAM memory cuts of one TCDM bank.

---
 rtl/tcdm_pipe_resp.sv | 100 ++++++++++
 tb/tb_tcdm_pipe_resp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tcdm_pipe_resp.sv
// tcdm_pipe_resp: response channel of one TCDM bank; merges SCM and (optionally pipelined) SRAM
// read returns into one r_valid/ID/rdata/opc stream and flags illegal same-cycle maturity.
module tcdm_pipe_resp #(
   parameter int MEM_WIDTH  = 11,
   parameter int ID_WIDTH   = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  data_req_i,
   input  logic                  data_gnt_i,
   input  logic [MEM_WIDTH-1:0]  data_add_i,
   input  logic                  data_wen_i,
   input  logic [ID_WIDTH-1:0]   data_ID_i,
   input  logic                  enable_pipe_req_i,
   input  logic                  enable_pipe_resp_i,
   input  logic [DATA_WIDTH-1:0] rdata_SCM_i,
   input  logic [DATA_WIDTH-1:0] rdata_SRAM_i,
   output logic                  data_r_valid_o,
   output logic [ID_WIDTH-1:0]   data_r_ID_o,
   output logic [DATA_WIDTH-1:0] data_r_rdata_o,
   output logic                  data_r_opc_o,
   output logic                  collision_o
);
   logic                  acc, to_scm, unused_add;
   logic                  scm_v_q, scm_wen_q;
   logic [ID_WIDTH-1:0]   scm_id_q;
   logic [2:0]            sv_q, swen_q, sresp_q;
   logic [ID_WIDTH-1:0]   sid_q [3];
   logic [1:0]            slat_q [3];
   logic [DATA_WIDTH-1:0] resp_q, last_rdata_q, sram_rd, scm_rd;
   logic [ID_WIDTH-1:0]   last_id_q;
   logic                  last_opc_q, collision_q, collision_d;
   logic [2:0]            mat, cap;
   logic [1:0]            sel;
   logic                  sram_mat, multi;

   assign acc        = data_req_i & data_gnt_i;
   assign to_scm     = data_add_i[MEM_WIDTH-1];
   assign unused_add = ^data_add_i[MEM_WIDTH-2:0];

   // Stage i holds SRAM tokens of age i+1; capture happens one cycle before maturity.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         mat[i] = sv_q[i] & (slat_q[i] == 2'(i + 1));
         cap[i] = sv_q[i] & sresp_q[i] & (slat_q[i] == 2'(i + 2));
      end
   end

   assign sel         = mat[0] ? 2'd0 : mat[1] ? 2'd1 : 2'd2;
   assign sram_mat    = |mat;
   assign multi       = (mat[0] & mat[1]) | (mat[0] & mat[2]) | (mat[1] & mat[2]);
   assign sram_rd     = swen_q[sel] ? (sresp_q[sel] ? resp_q : rdata_SRAM_i) : '0;
   assign scm_rd      = scm_wen_q ? rdata_SCM_i : '0;
   assign collision_d = collision_q | (sram_mat & scm_v_q) | multi;

   assign data_r_valid_o = sram_mat | scm_v_q;
   assign data_r_ID_o    = sram_mat ? sid_q[sel]  : scm_v_q ? scm_id_q  : last_id_q;
   assign data_r_opc_o   = sram_mat ? swen_q[sel] : scm_v_q ? scm_wen_q : last_opc_q;
   assign data_r_rdata_o = sram_mat ? sram_rd     : scm_v_q ? scm_rd    : last_rdata_q;
   assign collision_o    = collision_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scm_v_q      <= 1'b0;
         scm_wen_q    <= 1'b0;
         scm_id_q     <= '0;
         sv_q         <= '0;
         swen_q       <= '0;
         sresp_q      <= '0;
         for (int i = 0; i < 3; i++) begin
            sid_q[i]  <= '0;
            slat_q[i] <= '0;
         end
         resp_q       <= '0;
         last_rdata_q <= '0;
         last_id_q    <= '0;
         last_opc_q   <= 1'b0;
         collision_q  <= 1'b0;
      end else begin
         scm_v_q      <= acc & to_scm;
         scm_wen_q    <= data_wen_i;
         scm_id_q     <= data_ID_i;
         sv_q         <= {sv_q[1] & ~mat[1], sv_q[0] & ~mat[0], acc & ~to_scm};
         swen_q       <= {swen_q[1:0], data_wen_i};
         sresp_q      <= {sresp_q[1:0], enable_pipe_resp_i};
         sid_q[0]     <= data_ID_i;
         sid_q[1]     <= sid_q[0];
         sid_q[2]     <= sid_q[1];
         slat_q[0]    <= 2'd1 + 2'(enable_pipe_req_i) + 2'(enable_pipe_resp_i);
         slat_q[1]    <= slat_q[0];
         slat_q[2]    <= slat_q[1];
         if (|cap) resp_q <= rdata_SRAM_i;
         last_rdata_q <= data_r_rdata_o;
         last_id_q    <= data_r_ID_o;
         last_opc_q   <= data_r_opc_o;
         collision_q  <= collision_d;
      end
   end
endmodule

// File: tb/tb_tcdm_pipe_resp.sv
// tb_tcdm_pipe_resp: directed and randomized checks of tcdm_pipe_resp against a
// maturity-time scoreboard driven by recorded memory data history.
module tb_tcdm_pipe_resp;
   localparam int MW = 11, IW = 12, DW = 32;
   logic          clk = 1'b0, rst_n = 1'b0;
   logic          data_req_i = 0, data_gnt_i = 0, data_wen_i = 0;
   logic [MW-1:0] data_add_i = '0;
   logic [IW-1:0] data_ID_i = '0;
   logic          enable_pipe_req_i = 0, enable_pipe_resp_i = 0;
   logic [DW-1:0] rdata_SCM_i = '0, rdata_SRAM_i = '0;
   logic          data_r_valid_o, data_r_opc_o, collision_o;
   logic [IW-1:0] data_r_ID_o;
   logic [DW-1:0] data_r_rdata_o;

   tcdm_pipe_resp dut (
      .clk(clk), .rst_n(rst_n), .data_req_i(data_req_i), .data_gnt_i(data_gnt_i),
      .data_add_i(data_add_i), .data_wen_i(data_wen_i), .data_ID_i(data_ID_i),
      .enable_pipe_req_i(enable_pipe_req_i), .enable_pipe_resp_i(enable_pipe_resp_i),
      .rdata_SCM_i(rdata_SCM_i), .rdata_SRAM_i(rdata_SRAM_i),
      .data_r_valid_o(data_r_valid_o), .data_r_ID_o(data_r_ID_o),
      .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o), .collision_o(collision_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] id;
      logic          wen;
      logic          scm;
      int            mat;
      int            dcyc;
      int            acc;
   } tok_t;

   tok_t          pend[$];
   logic [DW-1:0] hs [0:4095];
   logic [DW-1:0] hm [0:4095];
   int            cyc_n = 0, n_chk = 0, n_err = 0;
   logic [IW-1:0] e_id = '0;
   logic          e_opc = 0, e_col = 0;
   logic [DW-1:0] e_rd = '0;

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_chk++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, cyc_n, o, e);
      end
   endtask

   function automatic bit slot_free(input int mat);
      foreach (pend[k]) if (pend[k].mat == mat) return 0;
      return 1;
   endfunction

   // One clock cycle: record memory data, check outputs at negedge, then log the accept.
   task automatic cyc();
      int   ns, si, sk;
      logic scm_m, e_v;
      tok_t t;
      hs[cyc_n] = rdata_SRAM_i;
      hm[cyc_n] = rdata_SCM_i;
      @(negedge clk);
      if (!rst_n) begin
         pend.delete();
         e_id = '0; e_opc = 0; e_rd = '0; e_col = 0; e_v = 0;
      end else begin
         ns = 0; si = -1; sk = -1; scm_m = 0;
         foreach (pend[k]) if (pend[k].mat == cyc_n) begin
            if (pend[k].scm) begin scm_m = 1; sk = k; end
            else begin
               ns++;
               if (si < 0 || pend[k].acc > pend[si].acc) si = k;
            end
         end
         e_v = scm_m || ns > 0;
         if (ns > 0) begin
            e_id = pend[si].id; e_opc = pend[si].wen;
            e_rd = pend[si].wen ? hs[pend[si].dcyc] : '0;
         end else if (scm_m) begin
            e_id = pend[sk].id; e_opc = pend[sk].wen;
            e_rd = pend[sk].wen ? hm[cyc_n] : '0;
         end
      end
      chk("valid", data_r_valid_o, e_v);
      chk("id", data_r_ID_o, e_id);
      chk("opc", data_r_opc_o, e_opc);
      chk("rdata", data_r_rdata_o, e_rd);
      chk("collision", collision_o, e_col);
      if (rst_n) begin
         if (scm_m && ns > 0 || ns > 1) e_col = 1;
         pend = pend.find with (item.mat != cyc_n);
         if (data_req_i && data_gnt_i) begin
            t.id = data_ID_i; t.wen = data_wen_i; t.scm = data_add_i[MW-1]; t.acc = cyc_n;
            t.mat = cyc_n + (t.scm ? 1 : 1 + int'(enable_pipe_req_i) + int'(enable_pipe_resp_i));
            t.dcyc = (!t.scm && enable_pipe_resp_i) ? t.mat - 1 : t.mat;
            pend.push_back(t);
         end
      end
      @(posedge clk);
      #1 cyc_n++;
   endtask

   task automatic req(input logic scm, input logic wen, input logic [IW-1:0] id,
                      input logic pq, input logic pr);
      data_req_i = 1; data_gnt_i = 1; data_wen_i = wen; data_ID_i = id;
      data_add_i = {scm, 10'($urandom)};
      enable_pipe_req_i = pq; enable_pipe_resp_i = pr;
      rdata_SCM_i = $urandom; rdata_SRAM_i = $urandom;
   endtask

   task automatic nop();
      data_req_i = $urandom; data_gnt_i = 0; data_wen_i = $urandom; data_ID_i = $urandom;
      data_add_i = $urandom; enable_pipe_req_i = $urandom; enable_pipe_resp_i = $urandom;
      rdata_SCM_i = $urandom; rdata_SRAM_i = $urandom;
   endtask

   initial begin
      nop();
      cyc(); cyc();
      rst_n = 1;
      nop(); cyc();
      // SCM load
      req(1, 1, 12'h05A, 0, 0); cyc();
      nop(); rdata_SCM_i = 32'hDEADBEEF;
      #1 chk("scm_id_const", data_r_ID_o, 12'h05A);
      chk("scm_rd_const", data_r_rdata_o, 32'hDEADBEEF);
      cyc(); nop(); cyc();
      // SRAM loads with pipes 00, 10, 11
      for (int p = 0; p < 3; p++) begin
         req(0, 1, 12'h123, p > 0, p > 1); cyc();
         for (int k = 1; k <= 3; k++) begin
            nop();
            rdata_SRAM_i = (k == 1 + (p > 0 ? 1 : 0)) ? 32'hCAFE0001 : 32'h0;
            cyc();
         end
      end
      // SRAM store, pipes 01
      req(0, 0, 12'h0FF, 0, 1); cyc();
      for (int k = 0; k < 3; k++) begin nop(); cyc(); end
      // back-to-back SCM loads
      req(1, 1, 12'h001, 0, 0); cyc();
      req(1, 1, 12'h002, 0, 0); rdata_SCM_i = 32'h11111111; cyc();
      nop(); rdata_SCM_i = 32'h22222222; cyc();
      nop(); cyc();
      // reset mid-flight
      req(0, 1, 12'h077, 1, 1); cyc();
      rst_n = 0; nop(); cyc();
      rst_n = 1;
      for (int k = 0; k < 4; k++) begin nop(); cyc(); end
      chk("col_after_rst", collision_o, 1'b0);
      // randomized legal traffic: grant withheld when the maturity slot is taken
      for (int k = 0; k < 600; k++) begin
         nop();
         data_req_i = $urandom_range(0, 3) != 0;
         if (slot_free(cyc_n + (data_add_i[MW-1] ? 1 :
                       1 + int'(enable_pipe_req_i) + int'(enable_pipe_resp_i))))
            data_gnt_i = $urandom_range(0, 4) != 0;
         cyc();
      end
      for (int k = 0; k < 4; k++) begin nop(); cyc(); end
      // collision
      req(0, 1, 12'h00A, 1, 1); cyc();
      nop(); cyc();
      req(1, 1, 12'h00B, 0, 0); cyc();
      nop(); cyc();
      for (int k = 0; k < 4; k++) begin nop(); cyc(); end
      chk("col_sticky", collision_o, 1'b1);
      rst_n = 0; nop(); cyc();
      rst_n = 1; nop(); cyc();
      chk("col_cleared", collision_o, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
